// File: rtl/mips_pkg.sv
// Shared MIPS load/store definitions: primary opcodes, load FSM states and
// the bus-lane to register-order byte swap used by both load and store paths.
package mips_pkg;

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LWL = 6'b100010;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LWR = 6'b100110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    RESP = 2'd2
  } load_state_t;

  // Lane k (bits [8k+7:8k]) holds the byte at base+k; register order puts the
  // lowest address in the most significant byte.
  function automatic logic [31:0] lane_swap(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  function automatic logic is_load(input logic [5:0] op);
    return (op == OP_LB) || (op == OP_LH) || (op == OP_LWL) || (op == OP_LW) ||
           (op == OP_LBU) || (op == OP_LHU) || (op == OP_LWR);
  endfunction

endpackage

// File: rtl/load_block_bus_if.sv
// Request/response and data-bus signals of the load block.
// slave: the load block itself; master: execute/writeback stages plus memory.
interface load_block_bus_if #(parameter int DEST_W = 5);

  logic              req_valid;
  logic              req_ready;
  logic [5:0]        opcode;
  logic [31:0]       eff_addr;
  logic [31:0]       regword;
  logic [DEST_W-1:0] dest_in;
  logic [31:0]       address;
  logic              read;
  logic              waitrequest;
  logic [31:0]       readdata;
  logic [3:0]        byteenable;
  logic              resp_valid;
  logic [31:0]       resp_data;
  logic [DEST_W-1:0] resp_dest;
  logic              addr_error;
  logic              bus_error;

  modport slave (
    input  req_valid, opcode, eff_addr, regword, dest_in, waitrequest, readdata,
    output req_ready, address, read, byteenable,
           resp_valid, resp_data, resp_dest, addr_error, bus_error
  );

  modport master (
    output req_valid, opcode, eff_addr, regword, dest_in, waitrequest, readdata,
    input  req_ready, address, read, byteenable,
           resp_valid, resp_data, resp_dest, addr_error, bus_error
  );

endinterface

// File: rtl/load_format.sv
// Combinational load result formatting: byte/halfword extraction with sign or
// zero extension, plain word, and lwl/lwr merge with the old register value.
module load_format
  import mips_pkg::*;
(
  input  logic [5:0]  opcode,
  input  logic [1:0]  k,
  input  logic [31:0] readdata,
  input  logic [31:0] regword,
  output logic [31:0] data
);

  logic [31:0] w;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] lwl_val;
  logic [31:0] lwr_val;

  // Select the addressed lanes and build every candidate result.
  always_comb begin
    w        = lane_swap(readdata);
    sel_half = k[1] ? w[15:0] : w[31:16];
    sel_byte = readdata[7:0];
    lwl_val  = w;
    lwr_val  = w;
    case (k)
      2'd0: begin
        sel_byte = readdata[7:0];
        lwl_val  = w;
        lwr_val  = {regword[31:8], w[31:24]};
      end
      2'd1: begin
        sel_byte = readdata[15:8];
        lwl_val  = {w[23:0], regword[7:0]};
        lwr_val  = {regword[31:16], w[31:16]};
      end
      2'd2: begin
        sel_byte = readdata[23:16];
        lwl_val  = {w[15:0], regword[15:0]};
        lwr_val  = {regword[31:24], w[31:8]};
      end
      default: begin
        sel_byte = readdata[31:24];
        lwl_val  = {w[7:0], regword[23:0]};
        lwr_val  = w;
      end
    endcase
  end

  // Pick the result for the captured opcode.
  always_comb begin
    data = 32'h0;
    case (opcode)
      OP_LB:   data = {{24{sel_byte[7]}}, sel_byte};
      OP_LBU:  data = {24'h0, sel_byte};
      OP_LH:   data = {{16{sel_half[15]}}, sel_half};
      OP_LHU:  data = {16'h0, sel_half};
      OP_LW:   data = w;
      OP_LWL:  data = lwl_val;
      OP_LWR:  data = lwr_val;
      default: data = 32'h0;
    endcase
  end

endmodule

// File: rtl/load_block_bus.sv
// Load block: accepts one load request, performs a word-aligned read on the
// data bus (riding out waitrequest with an optional timeout), formats the data
// and returns it to writeback with a one-cycle resp_valid pulse.
// Optional build macro LOAD_BLOCK_ALIGN_CHECK_EN: misaligned lh/lhu/lw skip the
// bus and respond with addr_error; without it, misalignment is silently
// aligned and addr_error stays 0.
//
// state | meaning
// IDLE  | ready for a request, no bus activity
// READ  | read strobe held until waitrequest drops or the stall limit hits
// RESP  | resp_valid pulse with data, destination and error flags
module load_block_bus
  import mips_pkg::*;
#(
  parameter int WAIT_LIMIT = 255,
  parameter int DEST_W     = 5
) (
  input  logic             clk,
  input  logic             reset,
  load_block_bus_if.slave  bus,
  output logic             busy
);

  localparam logic [15:0] LIMIT = 16'(WAIT_LIMIT);

  load_state_t       state;
  logic [5:0]        op_q;
  logic [1:0]        k_q;
  logic [31:0]       reg_q;
  logic [DEST_W-1:0] dest_q;
  logic [15:0]       wait_cnt;
  logic [15:0]       wait_cnt_next;
  logic [31:0]       fmt_data;
  logic [3:0]        be;
  logic [1:0]        k_in;
  logic              accept;
  logic              misaligned;

  assign accept        = bus.req_valid && bus.req_ready;
  assign k_in          = bus.eff_addr[1:0];
  assign wait_cnt_next = wait_cnt + 16'd1;

`ifdef LOAD_BLOCK_ALIGN_CHECK_EN
  assign misaligned = (((bus.opcode == OP_LH) || (bus.opcode == OP_LHU)) && k_in[0]) ||
                      ((bus.opcode == OP_LW) && (k_in != 2'd0));
`else
  assign misaligned = 1'b0;
`endif

  // Byte lanes for the incoming request; misaligned halfwords use the even lane pair.
  always_comb begin
    be = 4'b1111;
    case (bus.opcode)
      OP_LB, OP_LBU: be = 4'b0001 << k_in;
      OP_LH, OP_LHU: be = k_in[1] ? 4'b1100 : 4'b0011;
      default:       be = 4'b1111;
    endcase
  end

  load_format u_format (
    .opcode   (op_q),
    .k        (k_q),
    .readdata (bus.readdata),
    .regword  (reg_q),
    .data     (fmt_data)
  );

  // Load sequencing FSM with registered bus and response outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      op_q           <= 6'h0;
      k_q            <= 2'd0;
      reg_q          <= 32'h0;
      dest_q         <= '0;
      wait_cnt       <= 16'h0;
      bus.req_ready  <= 1'b1;
      bus.address    <= 32'h0;
      bus.read       <= 1'b0;
      bus.byteenable <= 4'h0;
      bus.resp_valid <= 1'b0;
      bus.resp_data  <= 32'h0;
      bus.resp_dest  <= '0;
      bus.addr_error <= 1'b0;
      bus.bus_error  <= 1'b0;
      busy           <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept && is_load(bus.opcode)) begin
            op_q          <= bus.opcode;
            k_q           <= k_in;
            reg_q         <= bus.regword;
            dest_q        <= bus.dest_in;
            wait_cnt      <= 16'h0;
            bus.req_ready <= 1'b0;
            busy          <= 1'b1;
            if (misaligned) begin
              state          <= RESP;
              bus.resp_valid <= 1'b1;
              bus.resp_data  <= 32'h0;
              bus.resp_dest  <= bus.dest_in;
              bus.addr_error <= 1'b1;
              bus.bus_error  <= 1'b0;
            end else begin
              state          <= READ;
              bus.read       <= 1'b1;
              bus.address    <= {bus.eff_addr[31:2], 2'b00};
              bus.byteenable <= be;
            end
          end
        end
        READ: begin
          if (!bus.waitrequest) begin
            state          <= RESP;
            bus.read       <= 1'b0;
            bus.address    <= 32'h0;
            bus.byteenable <= 4'h0;
            bus.resp_valid <= 1'b1;
            bus.resp_data  <= fmt_data;
            bus.resp_dest  <= dest_q;
            bus.addr_error <= 1'b0;
            bus.bus_error  <= 1'b0;
          end else if ((WAIT_LIMIT > 0) && (wait_cnt_next >= LIMIT)) begin
            state          <= RESP;
            wait_cnt       <= wait_cnt_next;
            bus.read       <= 1'b0;
            bus.address    <= 32'h0;
            bus.byteenable <= 4'h0;
            bus.resp_valid <= 1'b1;
            bus.resp_data  <= 32'h0;
            bus.resp_dest  <= dest_q;
            bus.addr_error <= 1'b0;
            bus.bus_error  <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt_next;
          end
        end
        RESP: begin
          state          <= IDLE;
          wait_cnt       <= 16'h0;
          bus.resp_valid <= 1'b0;
          bus.resp_data  <= 32'h0;
          bus.resp_dest  <= '0;
          bus.addr_error <= 1'b0;
          bus.bus_error  <= 1'b0;
          bus.req_ready  <= 1'b1;
          busy           <= 1'b0;
        end
        default: begin
          state          <= IDLE;
          bus.read       <= 1'b0;
          bus.resp_valid <= 1'b0;
          bus.req_ready  <= 1'b1;
          busy           <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_block_bus.sv
// Directed bench for load_block_bus: checks reset state, byte/halfword/word
// and lwl/lwr formatting, waitrequest stalls, timeout, misaligned word and
// asynchronous reset during a read.
module tb_load_block_bus;
  import mips_pkg::*;

  logic clk;
  logic reset;
  logic busy;
  int   vectors;
  int   miscompares;
  logic saw_resp;

  load_block_bus_if #(.DEST_W(5)) bif ();

  load_block_bus #(.WAIT_LIMIT(4), .DEST_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif.slave),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [5:0] op, input logic [31:0] addr,
                      input logic [31:0] rw, input logic [4:0] dest);
    bif.req_valid = 1'b1;
    bif.opcode    = op;
    bif.eff_addr  = addr;
    bif.regword   = rw;
    bif.dest_in   = dest;
    @(negedge clk);
    bif.req_valid = 1'b0;
  endtask

  initial begin
    vectors          = 0;
    miscompares      = 0;
    saw_resp         = 1'b0;
    reset            = 1'b1;
    bif.req_valid    = 1'b0;
    bif.opcode       = 6'h0;
    bif.eff_addr     = 32'h0;
    bif.regword      = 32'h0;
    bif.dest_in      = 5'd0;
    bif.waitrequest  = 1'b0;
    bif.readdata     = 32'h0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // reset state
    chk("rst_req_ready", bif.req_ready, 1);
    chk("rst_read", bif.read, 0);
    chk("rst_busy", busy, 0);
    chk("rst_resp_valid", bif.resp_valid, 0);
    chk("rst_resp_data", bif.resp_data, 0);
    chk("rst_be", bif.byteenable, 0);

    // lb at 0x1003, lane3 = 0x80
    bif.readdata = 32'h8000_0000;
    send(OP_LB, 32'h0000_1003, 32'h0, 5'd7);
    chk("lb_read", bif.read, 1);
    chk("lb_addr", bif.address, 32'h0000_1000);
    chk("lb_be", bif.byteenable, 4'b1000);
    chk("lb_busy", busy, 1);
    chk("lb_req_ready", bif.req_ready, 0);
    chk("lb_no_early_resp", bif.resp_valid, 0);
    @(negedge clk);
    chk("lb_resp_valid", bif.resp_valid, 1);
    chk("lb_data", bif.resp_data, 32'hFFFF_FF80);
    chk("lb_dest", bif.resp_dest, 5'd7);
    chk("lb_read_drop", bif.read, 0);
    chk("lb_errs", {bif.addr_error, bif.bus_error}, 2'b00);
    @(negedge clk);
    chk("lb_pulse_end", bif.resp_valid, 0);
    chk("lb_idle_ready", bif.req_ready, 1);
    chk("lb_idle_busy", busy, 0);

    // lhu at 0x2002, 3 stall cycles -> read held 4 cycles
    bif.readdata    = 32'hBEEF_1234;
    bif.waitrequest = 1'b1;
    send(OP_LHU, 32'h0000_2002, 32'h0, 5'd3);
    chk("lhu_read_c1", bif.read, 1);
    chk("lhu_be", bif.byteenable, 4'b1100);
    @(negedge clk);
    chk("lhu_read_c2", bif.read, 1);
    @(negedge clk);
    chk("lhu_read_c3", bif.read, 1);
    @(negedge clk);
    chk("lhu_read_c4", bif.read, 1);
    chk("lhu_no_resp_yet", bif.resp_valid, 0);
    bif.waitrequest = 1'b0;
    @(negedge clk);
    chk("lhu_read_drop", bif.read, 0);
    chk("lhu_resp_valid", bif.resp_valid, 1);
    chk("lhu_data", bif.resp_data, 32'h0000_EFBE);
    chk("lhu_bus_error", bif.bus_error, 0);
    @(negedge clk);

    // lwl k=1 then lwr k=1
    bif.readdata = 32'h4433_2211;
    send(OP_LWL, 32'h0000_4001, 32'hAABB_CCDD, 5'd9);
    chk("lwl_be", bif.byteenable, 4'b1111);
    chk("lwl_addr", bif.address, 32'h0000_4000);
    @(negedge clk);
    chk("lwl_data", bif.resp_data, 32'h2233_44DD);
    chk("lwl_dest", bif.resp_dest, 5'd9);
    @(negedge clk);
    send(OP_LWR, 32'h0000_4001, 32'hAABB_CCDD, 5'd10);
    @(negedge clk);
    chk("lwr_data", bif.resp_data, 32'hAABB_1122);
    chk("lwr_valid", bif.resp_valid, 1);
    @(negedge clk);

    // lh k=0 negative, lbu k=1
    bif.readdata = 32'h0000_7F85;
    send(OP_LH, 32'h0000_6000, 32'h0, 5'd1);
    chk("lh_be", bif.byteenable, 4'b0011);
    @(negedge clk);
    chk("lh_data", bif.resp_data, 32'hFFFF_857F);
    @(negedge clk);
    bif.readdata = 32'h0000_9A00;
    send(OP_LBU, 32'h0000_6001, 32'h0, 5'd2);
    chk("lbu_be", bif.byteenable, 4'b0010);
    @(negedge clk);
    chk("lbu_data", bif.resp_data, 32'h0000_009A);
    @(negedge clk);

    // timeout: WAIT_LIMIT=4, waitrequest stuck high
    bif.waitrequest = 1'b1;
    bif.readdata    = 32'h1234_5678;
    send(OP_LW, 32'h0000_5000, 32'h0, 5'd4);
    chk("to_read_c1", bif.read, 1);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("to_read_c4", bif.read, 1);
    chk("to_no_resp_c4", bif.resp_valid, 0);
    @(negedge clk);
    chk("to_read_drop", bif.read, 0);
    chk("to_resp_valid", bif.resp_valid, 1);
    chk("to_bus_error", bif.bus_error, 1);
    chk("to_addr_error", bif.addr_error, 0);
    chk("to_data", bif.resp_data, 32'h0);
    chk("to_dest", bif.resp_dest, 5'd4);
    bif.waitrequest = 1'b0;
    @(negedge clk);
    chk("to_pulse_end", bif.resp_valid, 0);

    // lw at 0x3002
    bif.readdata = 32'hDDCC_BBAA;
    send(OP_LW, 32'h0000_3002, 32'h0, 5'd5);
`ifdef LOAD_BLOCK_ALIGN_CHECK_EN
    chk("mis_no_read", bif.read, 0);
    chk("mis_resp_valid", bif.resp_valid, 1);
    chk("mis_addr_error", bif.addr_error, 1);
    chk("mis_data", bif.resp_data, 32'h0);
    @(negedge clk);
    chk("mis_pulse_end", bif.resp_valid, 0);
`else
    chk("mis_read", bif.read, 1);
    chk("mis_addr", bif.address, 32'h0000_3000);
    chk("mis_be", bif.byteenable, 4'b1111);
    @(negedge clk);
    chk("mis_data", bif.resp_data, 32'hAABB_CCDD);
    chk("mis_addr_error", bif.addr_error, 0);
`endif
    @(negedge clk);

    // non-load opcode is consumed without bus access or response
    send(6'b101011, 32'h0000_8000, 32'h0, 5'd6);
    chk("nl_read", bif.read, 0);
    chk("nl_busy", busy, 0);
    chk("nl_ready", bif.req_ready, 1);
    @(negedge clk);
    chk("nl_no_resp", bif.resp_valid, 0);

    // reset mid-READ
    bif.waitrequest = 1'b1;
    send(OP_LW, 32'h0000_7000, 32'h0, 5'd8);
    @(negedge clk);
    chk("rr_read_before", bif.read, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("rr_read", bif.read, 0);
    chk("rr_busy", busy, 0);
    chk("rr_resp_valid", bif.resp_valid, 0);
    chk("rr_req_ready", bif.req_ready, 1);
    @(negedge clk);
    reset           = 1'b0;
    bif.waitrequest = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (bif.resp_valid) saw_resp = 1'b1;
    end
    chk("rr_no_response", saw_resp, 0);

    // recovery after reset
    bif.readdata = 32'h0000_00C3;
    send(OP_LBU, 32'h0000_9000, 32'h0, 5'd11);
    @(negedge clk);
    chk("rec_data", bif.resp_data, 32'h0000_00C3);
    chk("rec_dest", bif.resp_dest, 5'd11);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/load_block_bus.md
Name: load_block_bus

Overview:
- Load-side counterpart of the store path in the MIPS core.
- Accepts one load request from the execute stage and issues a word-aligned read on the Avalon-style data bus, waiting out waitrequest.
- Extracts and extends the requested byte, halfword or word, with lwl/lwr merging into the old register value.
- Returns the result and destination register to writeback with a one-cycle response pulse.

Parameters:
- WAIT_LIMIT, 255, maximum consecutive waitrequest cycles before bus_error; 0 disables the timeout.
- DEST_W, 5, destination register index width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- req_valid  in  1  load request present
- req_ready  out  1  block can accept a request
- opcode  in  6  MIPS primary opcode of the load
- eff_addr  in  32  effective byte address
- regword  in  32  current destination register value, used by lwl/lwr
- dest_in  in  DEST_W  destination register index
- address  out  32  bus word address, eff_addr with [1:0] forced to 0
- read  out  1  bus read strobe
- waitrequest  in  1  bus stall
- readdata  in  32  bus read data; lane k is bits [8k+7:8k] and holds the byte at base+k
- byteenable  out  4  lanes requested
- resp_valid  out  1  one-cycle result pulse
- resp_data  out  32  loaded, extended or merged value
- resp_dest  out  DEST_W  echo of dest_in
- addr_error  out  1  misaligned access, valid with resp_valid
- bus_error  out  1  timeout, valid with resp_valid
- busy  out  1  state is not IDLE

Behaviour:
- Reset (async, any state): state=IDLE, all outputs 0 except req_ready=1; wait counter cleared; an in-flight read is abandoned.
- Opcodes: lb 100000, lh 100001, lwl 100010, lw 100011, lbu 100100, lhu 100101, lwr 100110.
- Other opcodes: consumed in IDLE with no bus access and no response.
- Handshake: the request is accepted on the clk edge where req_valid and req_ready are both 1. req_ready=1 only in IDLE.
- Accept captures opcode, eff_addr[1:0] (k), regword and dest_in.
- State IDLE: on accepting a load, go to READ with read=1, address driven and byteenable driven.
  - byteenable: lb/lbu = one-hot lane k; lh/lhu = 0011 (k=0) or 1100 (k=2); others = 1111.
- State READ: read stays high while waitrequest=1, and the counter increments each such cycle.
  - When waitrequest=0: capture readdata, drop read, go to RESP.
  - If the counter reaches WAIT_LIMIT (WAIT_LIMIT>0): drop read, go to RESP with bus_error=1 and resp_data=0.
- State RESP: resp_valid=1 for exactly one cycle with resp_data, resp_dest and the error flags; then go to IDLE. Minimum latency is accept to resp_valid = 2 cycles.
- Data formatting: the register-order word is W = {lane0, lane1, lane2, lane3} (big-endian, lowest address most significant).
  - Byte k = lane k. lb sign-extends, lbu zero-extends.
  - Halfword: {lane0,lane1} for k=0, {lane2,lane3} for k=2. lh sign-extends, lhu zero-extends.
  - lw = W.
  - lwl = (W << 8k) | (regword & ((1<<8k)-1)).
  - lwr = (W >> 8(3-k)) | (regword & ~(32'hFFFFFFFF >> 8(3-k))).
- Error flags are 0 on a normal response. addr_error and bus_error are never both 1.

Optional Feature:
- Macro LOAD_BLOCK_ALIGN_CHECK_EN.
- Defined: lh/lhu with k odd, or lw with k≠0, skips the bus entirely. The block goes IDLE→RESP directly (latency 1) with addr_error=1 and resp_data=0.
- Undefined: no check. Misaligned lh/lhu use k with bit0 cleared; misaligned lw ignores k. addr_error is tied to 0.

Decomposition:
- Shared package mips_pkg holds:
  - opcode localparams OP_LB…OP_LWR, shared with the store path;
  - state enum typedef load_state_t {IDLE, READ, RESP};
  - the lane-to-register-order byte-swap function, also used for stores.
- One natural sub-module, load_format: purely combinational. Takes captured opcode, k, readdata and regword; produces resp_data.

Test Plan:
- lb at 0x1003, readdata=0x80_00_00_00, waitrequest=0 → byteenable=1000, resp_data=0xFFFFFF80, resp_valid 2 cycles after accept.
- lhu at 0x2002, readdata=0xBEEF1234, waitrequest high 3 cycles → read held 4 cycles, resp_data=0x0000EFBE (lane2=0xEF, lane3=0xBE), byteenable=1100.
- lwl k=1 then lwr k=1, readdata=0x44332211, regword=0xAABBCCDD → lwl: 0x223344DD; lwr: 0xAABB1122.
- WAIT_LIMIT=4, waitrequest stuck 1 → read drops after 4 stall cycles, resp_valid with bus_error=1, resp_data=0.
- With LOAD_BLOCK_ALIGN_CHECK_EN, lw at 0x3002 → no read asserted, addr_error=1 next cycle. Without the macro, the same request reads 0x3000 normally.
- reset asserted mid-READ → read, busy and resp_valid go 0 immediately, req_ready=1; no response is emitted for the abandoned load.
